encap_tunnel_lookup_ctrl: RTL and testbench
===========================================

Name: encap_tunnel_lookup_ctrl

Overview:
Sequences one tunnel lookup at a time against the two-way tunnel hash tables and the tunnel value memory inside the encap tunnel memory wrapper.
- Accepts a lookup request carrying a key and two hash indices.
- Issues parallel bucket reads to table0 and table1, then compares the 4 bucket entries of each against the key.
- On a hit, fetches the tunnel value record and returns it on a valid/ready response port.
- Sits between the encap header-build pipeline and the memory wrapper's application read ports.

Parameters:
DEPTH_NBITS, `TUNNEL_HASH_TABLE_DEPTH_NBITS, hash table index width
VALUE_DEPTH_NBITS, `TUNNEL_VALUE_DEPTH_NBITS, value memory index width
VALUE_NBITS, `TUNNEL_VALUE_NBITS, value record width
KEY_NBITS, 32, lookup key width
ENTRY_NBITS, 1+KEY_NBITS+VALUE_DEPTH_NBITS, bucket entry {valid, key, vptr}, valid at MSB
BUCKET_NBITS, 4*ENTRY_NBITS, bucket width; entry i at bits [ENTRY_NBITS*(i+1)-1 : ENTRY_NBITS*i]
ID_NBITS, 8, request tag width
TIMEOUT, 255, max cycles waiting for any ack

Ports:
clk  in  1  clock
`RESET_SIG  in  1  reset, synchronous, active-low; port name per `RESET_SIG
req_valid  in  1  lookup request valid
req_ready  out  1  block can accept request
req_key  in  KEY_NBITS  lookup key
req_idx0  in  DEPTH_NBITS  table0 bucket index
req_idx1  in  DEPTH_NBITS  table1 bucket index
req_id  in  ID_NBITS  request tag
tunnel_hash_table0_rd  out  1  table0 read strobe
tunnel_hash_table0_raddr  out  DEPTH_NBITS  table0 read address
tunnel_hash_table0_ack  in  1  table0 read data valid
tunnel_hash_table0_rdata  in  BUCKET_NBITS  table0 bucket
tunnel_hash_table1_rd/raddr/ack/rdata  same as table0, for table1
tunnel_value_rd  out  1  value read strobe
tunnel_value_raddr  out  VALUE_DEPTH_NBITS  value read address
tunnel_value_ack  in  1  value data valid
tunnel_value_rdata  in  VALUE_NBITS  value record
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_NBITS  echoed req_id
rsp_hit  out  1  key found
rsp_err  out  1  ack timeout on this lookup
rsp_value  out  VALUE_NBITS  value record; 0 on miss or error
err_timeout  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (sampled on clk): state IDLE; all outputs 0 except req_ready=1; timeout counter 0; ack latches cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, capture key, idx0, idx1 and id.
  - Same cycle: pulse both table rd strobes for exactly 1 cycle, raddr = captured indices.
  - Go to HT_WAIT.
- HT_WAIT:
  - Latch table0 and table1 ack/rdata independently; acks may arrive in any order or the same cycle.
  - Exit when both are latched: go to CMP.
  - If the counter reaches TIMEOUT first: rsp_err=1, err_timeout=1, go to RESP.
- CMP (1 cycle):
  - Hit when entry valid=1 and entry key==req_key.
  - Priority: table0 entry0..3, then table1 entry0..3; first hit wins.
  - On hit: pulse tunnel_value_rd with raddr=vptr, go to VAL_WAIT.
  - On miss: rsp_hit=0, go to RESP.
- VAL_WAIT:
  - On tunnel_value_ack: rsp_hit=1, rsp_value=rdata, go to RESP.
  - On timeout: as in HT_WAIT.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE; req_ready returns next cycle (no same-cycle re-accept).
- Latency, ack same cycle as rd (zero-wait memory):
  - miss: request to rsp_valid = 2 cycles;
  - hit: 3 cycles.
- Timeout counter:
  - cleared on entry to HT_WAIT and VAL_WAIT;
  - increments each cycle waiting;
  - expires when count==TIMEOUT (TIMEOUT cycles without completion).
- Acks arriving outside HT_WAIT/VAL_WAIT are ignored; rd strobes never reissued within one lookup.
- req_ready=0 in every state except IDLE; at most one lookup outstanding.
- Reset asserted mid-lookup: abort immediately to IDLE; any pending response is dropped.
- Duplicate matching entries: lowest-priority-index entry wins.

Test Plan:
- Reset, then key 0x1234 idx0=5 idx1=9; table0 bucket entry2={1,0x1234,vptr=7}; value[7]=pattern A; zero-wait acks -> rsp_hit=1, rsp_value=A, rsp_id echoed, rsp_valid 3 cycles after accept.
- Key 0x55 present only in table1 entry3, table0 entry0 has valid=0 with key 0x55 -> hit via table1 vptr; value rd raddr equals table1 vptr.
- No match in either bucket -> rsp_hit=0, rsp_value=0, tunnel_value_rd never pulses, rsp_valid 2 cycles after accept.
- table1 ack 4 cycles after table0 ack; hold rsp_ready=0 for 10 cycles -> correct compare; rsp fields stable; req_ready=0 until handshake completes.
- Withhold tunnel_value_ack -> after 255 wait cycles rsp_err=1, rsp_hit=0, err_timeout=1 and stays 1 across later lookups until reset.
- Assert reset in VAL_WAIT -> next cycle req_ready=1, rsp_valid=0, all strobes 0; a new lookup completes normally.

Source files
------------

// File: rtl/encap_tunnel_lookup_ctrl.sv
// Sequences one tunnel lookup at a time: two-way bucket reads, an 8-entry key compare,
// then an optional value fetch, with the result returned on a valid/ready response port.
module encap_tunnel_lookup_ctrl #(
   parameter int DEPTH_NBITS       = 10,
   parameter int VALUE_DEPTH_NBITS = 10,
   parameter int VALUE_NBITS       = 64,
   parameter int KEY_NBITS         = 32,
   parameter int ENTRY_NBITS       = 1 + KEY_NBITS + VALUE_DEPTH_NBITS,
   parameter int BUCKET_NBITS      = 4 * ENTRY_NBITS,
   parameter int ID_NBITS          = 8,
   parameter int TIMEOUT           = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [KEY_NBITS-1:0]         req_key,
   input  logic [DEPTH_NBITS-1:0]       req_idx0,
   input  logic [DEPTH_NBITS-1:0]       req_idx1,
   input  logic [ID_NBITS-1:0]          req_id,
   output logic                         tunnel_hash_table0_rd,
   output logic [DEPTH_NBITS-1:0]       tunnel_hash_table0_raddr,
   input  logic                         tunnel_hash_table0_ack,
   input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table0_rdata,
   output logic                         tunnel_hash_table1_rd,
   output logic [DEPTH_NBITS-1:0]       tunnel_hash_table1_raddr,
   input  logic                         tunnel_hash_table1_ack,
   input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table1_rdata,
   output logic                         tunnel_value_rd,
   output logic [VALUE_DEPTH_NBITS-1:0] tunnel_value_raddr,
   input  logic                         tunnel_value_ack,
   input  logic [VALUE_NBITS-1:0]       tunnel_value_rdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [ID_NBITS-1:0]          rsp_id,
   output logic                         rsp_hit,
   output logic                         rsp_err,
   output logic [VALUE_NBITS-1:0]       rsp_value,
   output logic                         err_timeout
);

   localparam int CNT_NBITS = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      HT_WAIT,
      CMP,
      VAL_WAIT,
      RESP
   } state_t;

   state_t                         state;
   logic [KEY_NBITS-1:0]           key;
   logic [ID_NBITS-1:0]            id;
   logic                           got0;
   logic                           got1;
   logic [BUCKET_NBITS-1:0]        bucket0;
   logic [BUCKET_NBITS-1:0]        bucket1;
   logic [CNT_NBITS-1:0]           wait_cnt;
   logic [CNT_NBITS-1:0]           wait_next;
   logic                           expired;
   logic [2*BUCKET_NBITS-1:0]      buckets;
   logic [ENTRY_NBITS-1:0]         entry;
   logic                           match;
   logic [VALUE_DEPTH_NBITS-1:0]   match_vptr;

   assign wait_next = wait_cnt + CNT_NBITS'(1);
   assign expired   = (wait_next == CNT_NBITS'(TIMEOUT));
   assign buckets   = {bucket1, bucket0};

   // Scanning from the last entry down lets the lowest index (table0 entry0 first) win.
   always_comb begin
      match      = 1'b0;
      match_vptr = '0;
      entry      = '0;
      for (int i = 7; i >= 0; i--) begin
         entry = buckets[i*ENTRY_NBITS +: ENTRY_NBITS];
         if (entry[ENTRY_NBITS-1] && (entry[ENTRY_NBITS-2 -: KEY_NBITS] == key)) begin
            match      = 1'b1;
            match_vptr = entry[VALUE_DEPTH_NBITS-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                    <= IDLE;
         req_ready                <= 1'b1;
         key                      <= '0;
         id                       <= '0;
         got0                     <= 1'b0;
         got1                     <= 1'b0;
         bucket0                  <= '0;
         bucket1                  <= '0;
         wait_cnt                 <= '0;
         tunnel_hash_table0_rd    <= 1'b0;
         tunnel_hash_table0_raddr <= '0;
         tunnel_hash_table1_rd    <= 1'b0;
         tunnel_hash_table1_raddr <= '0;
         tunnel_value_rd          <= 1'b0;
         tunnel_value_raddr       <= '0;
         rsp_valid                <= 1'b0;
         rsp_id                   <= '0;
         rsp_hit                  <= 1'b0;
         rsp_err                  <= 1'b0;
         rsp_value                <= '0;
         err_timeout              <= 1'b0;
      end else begin
         tunnel_hash_table0_rd <= 1'b0;
         tunnel_hash_table1_rd <= 1'b0;
         tunnel_value_rd       <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  key                      <= req_key;
                  id                       <= req_id;
                  tunnel_hash_table0_rd    <= 1'b1;
                  tunnel_hash_table0_raddr <= req_idx0;
                  tunnel_hash_table1_rd    <= 1'b1;
                  tunnel_hash_table1_raddr <= req_idx1;
                  req_ready                <= 1'b0;
                  got0                     <= 1'b0;
                  got1                     <= 1'b0;
                  wait_cnt                 <= '0;
                  state                    <= HT_WAIT;
               end
            end
            HT_WAIT: begin
               if (tunnel_hash_table0_ack && !got0) begin
                  got0    <= 1'b1;
                  bucket0 <= tunnel_hash_table0_rdata;
               end
               if (tunnel_hash_table1_ack && !got1) begin
                  got1    <= 1'b1;
                  bucket1 <= tunnel_hash_table1_rdata;
               end
               if ((got0 || tunnel_hash_table0_ack) && (got1 || tunnel_hash_table1_ack)) begin
                  state <= CMP;
               end else if (expired) begin
                  rsp_valid   <= 1'b1;
                  rsp_id      <= id;
                  rsp_hit     <= 1'b0;
                  rsp_err     <= 1'b1;
                  rsp_value   <= '0;
                  err_timeout <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_next;
               end
            end
            CMP: begin
               if (match) begin
                  tunnel_value_rd    <= 1'b1;
                  tunnel_value_raddr <= match_vptr;
                  wait_cnt           <= '0;
                  state              <= VAL_WAIT;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_hit   <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_value <= '0;
                  state     <= RESP;
               end
            end
            VAL_WAIT: begin
               if (tunnel_value_ack) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_hit   <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_value <= tunnel_value_rdata;
                  state     <= RESP;
               end else if (expired) begin
                  rsp_valid   <= 1'b1;
                  rsp_id      <= id;
                  rsp_hit     <= 1'b0;
                  rsp_err     <= 1'b1;
                  rsp_value   <= '0;
                  err_timeout <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_next;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_hit   <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_value <= '0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encap_tunnel_lookup_ctrl.sv
// Randomized bench for encap_tunnel_lookup_ctrl: table/value memories with programmable ack
// delays, and a lookup model that scans the stored entries in priority order.
module tb_encap_tunnel_lookup_ctrl;

   localparam int DN = 6;
   localparam int VD = 8;
   localparam int VN = 64;
   localparam int KN = 32;
   localparam int EN = 1 + KN + VD;
   localparam int BN = 4 * EN;
   localparam int IN = 8;
   localparam int TIMEOUT = 255;
   localparam int NB = 1 << DN;
   localparam int NV = 1 << VD;

   typedef struct {
      bit          valid;
      bit [KN-1:0] key;
      bit [VD-1:0] vptr;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [KN-1:0] req_key = '0;
   logic [DN-1:0] req_idx0 = '0;
   logic [DN-1:0] req_idx1 = '0;
   logic [IN-1:0] req_id = '0;
   logic          t0_rd, t1_rd, v_rd;
   logic [DN-1:0] t0_raddr, t1_raddr;
   logic [VD-1:0] v_raddr;
   logic          t0_ack = 1'b0, t1_ack = 1'b0, v_ack = 1'b0;
   logic [BN-1:0] t0_rdata = '0, t1_rdata = '0;
   logic [VN-1:0] v_rdata = '0;
   logic          rsp_valid, rsp_hit, rsp_err, err_timeout;
   logic          rsp_ready = 1'b0;
   logic [IN-1:0] rsp_id;
   logic [VN-1:0] rsp_value;

   ent_t        tbls [2][NB][4];
   logic [VN-1:0] vals [NV];

   int d0 = 0, d1 = 0, dv = 0;
   bit withholdV = 1'b0;
   int rd0Count = 0, rd1Count = 0, vrdCount = 0;
   logic [DN-1:0] rd0Addr = '0, rd1Addr = '0;
   logic [VD-1:0] vrdAddr = '0;
   int checks = 0, errors = 0;
   bit stickyErr = 1'b0;

   encap_tunnel_lookup_ctrl #(
      .DEPTH_NBITS(DN), .VALUE_DEPTH_NBITS(VD), .VALUE_NBITS(VN), .KEY_NBITS(KN),
      .ID_NBITS(IN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
      .req_idx0(req_idx0), .req_idx1(req_idx1), .req_id(req_id),
      .tunnel_hash_table0_rd(t0_rd), .tunnel_hash_table0_raddr(t0_raddr),
      .tunnel_hash_table0_ack(t0_ack), .tunnel_hash_table0_rdata(t0_rdata),
      .tunnel_hash_table1_rd(t1_rd), .tunnel_hash_table1_raddr(t1_raddr),
      .tunnel_hash_table1_ack(t1_ack), .tunnel_hash_table1_rdata(t1_rdata),
      .tunnel_value_rd(v_rd), .tunnel_value_raddr(v_raddr),
      .tunnel_value_ack(v_ack), .tunnel_value_rdata(v_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
      .rsp_err(rsp_err), .rsp_value(rsp_value), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [BN-1:0] packBucket(input int t, input int a);
      logic [BN-1:0] b;
      b = '0;
      for (int e = 0; e < 4; e++)
         b[e*EN +: EN] = {tbls[t][a][e].valid, tbls[t][a][e].key, tbls[t][a][e].vptr};
      return b;
   endfunction

   // Lookup semantics: first valid entry with the key, table0 entries 0..3 before table1.
   task automatic refLookup(input logic [KN-1:0] k, input int i0, input int i1,
                            output bit hit, output int vptr);
      int idx [2];
      idx[0] = i0;
      idx[1] = i1;
      hit = 1'b0;
      vptr = 0;
      for (int t = 0; t < 2; t++)
         for (int e = 0; e < 4; e++)
            if (!hit && tbls[t][idx[t]][e].valid && tbls[t][idx[t]][e].key == k) begin
               hit = 1'b1;
               vptr = int'(tbls[t][idx[t]][e].vptr);
            end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory responders: ack the strobe after the programmed number of cycles (0 = same cycle).
   initial begin : table0Mem
      int a;
      forever begin
         @(posedge clk); #1;
         if (t0_rd) begin
            a = int'(t0_raddr);
            for (int k = 0; k < d0; k++) begin @(posedge clk); #1; end
            t0_ack = 1'b1; t0_rdata = packBucket(0, a);
            @(posedge clk); #1;
            t0_ack = 1'b0; t0_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   initial begin : table1Mem
      int a;
      forever begin
         @(posedge clk); #1;
         if (t1_rd) begin
            a = int'(t1_raddr);
            for (int k = 0; k < d1; k++) begin @(posedge clk); #1; end
            t1_ack = 1'b1; t1_rdata = packBucket(1, a);
            @(posedge clk); #1;
            t1_ack = 1'b0; t1_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   initial begin : valueMem
      int a;
      forever begin
         @(posedge clk); #1;
         if (v_rd && !withholdV) begin
            a = int'(v_raddr);
            for (int k = 0; k < dv; k++) begin @(posedge clk); #1; end
            v_ack = 1'b1; v_rdata = vals[a];
            @(posedge clk); #1;
            v_ack = 1'b0; v_rdata = {$urandom, $urandom};
         end
      end
   end

   always @(negedge clk) begin
      if (t0_rd) begin rd0Count++; rd0Addr = t0_raddr; end
      if (t1_rd) begin rd1Count++; rd1Addr = t1_raddr; end
      if (v_rd) begin vrdCount++; vrdAddr = v_raddr; end
   end

   // One full lookup: issue request, measure latency, check response, hold, then handshake.
   task automatic applyStimulus(input logic [KN-1:0] k, input int i0, input int i1,
                                input logic [IN-1:0] id, input int hold);
      bit expHit, expRspHit, expErr;
      int expVptr, maxd, expLat, lat, c0, c1, cv;
      logic [VN-1:0] expVal;
      refLookup(k, i0, i1, expHit, expVptr);
      maxd = (d0 > d1) ? d0 : d1;
      expErr = expHit && withholdV;
      expRspHit = expHit && !withholdV;
      if (!expHit) expLat = maxd + 2;
      else if (withholdV) expLat = maxd + 2 + TIMEOUT;
      else expLat = maxd + 3 + dv;
      expVal = expRspHit ? vals[expVptr] : '0;
      if (expErr) stickyErr = 1'b1;

      @(posedge clk); #1;
      checkOutput("req_ready_idle", req_ready, 1);
      c0 = rd0Count; c1 = rd1Count; cv = vrdCount;
      req_valid = 1'b1; req_key = k; req_idx0 = DN'(i0); req_idx1 = DN'(i1); req_id = id;
      @(posedge clk); #1;
      req_valid = 1'b0; req_key = $urandom; req_id = IN'($urandom);
      checkOutput("req_ready_busy", req_ready, 0);
      lat = 0;
      while (!rsp_valid && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         checkOutput("rsp_valid_bound", 0, 1);
         return;
      end
      checkOutput("latency", lat, expLat);
      checkOutput("rsp_hit", rsp_hit, expRspHit);
      checkOutput("rsp_err", rsp_err, expErr);
      checkOutput("rsp_value", rsp_value, expVal);
      checkOutput("rsp_id", rsp_id, id);
      checkOutput("err_timeout", err_timeout, stickyErr);
      checkOutput("t0_rd_pulses", rd0Count - c0, 1);
      checkOutput("t1_rd_pulses", rd1Count - c1, 1);
      checkOutput("t0_raddr", rd0Addr, i0);
      checkOutput("t1_raddr", rd1Addr, i1);
      checkOutput("v_rd_pulses", vrdCount - cv, expHit ? 1 : 0);
      if (expHit) checkOutput("v_raddr", vrdAddr, expVptr);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", rsp_valid, 1);
         checkOutput("hold_value", rsp_value, expVal);
         checkOutput("hold_id", rsp_id, id);
         checkOutput("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("post_valid", rsp_valid, 0);
      checkOutput("post_req_ready", req_ready, 1);
   endtask

   task automatic clearBucket(input int t, input int a);
      for (int e = 0; e < 4; e++) begin
         tbls[t][a][e].valid = 1'b0;
         tbls[t][a][e].key = '0;
         tbls[t][a][e].vptr = '0;
      end
   endtask

   task automatic randomBucket(input int t, input int a, input logic [KN-1:0] k);
      for (int e = 0; e < 4; e++) begin
         tbls[t][a][e].valid = bit'($urandom_range(0, 1));
         tbls[t][a][e].key = ($urandom_range(0, 3) == 0) ? k : KN'($urandom);
         tbls[t][a][e].vptr = VD'($urandom);
      end
   endtask

   initial begin : main
      logic [KN-1:0] k;
      int i0, i1, b;
      for (int t = 0; t < 2; t++)
         for (int a = 0; a < NB; a++) clearBucket(t, a);
      for (int v = 0; v < NV; v++) vals[v] = {$urandom, $urandom};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", req_ready, 1);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_strobes", {t0_rd, t1_rd, v_rd}, 0);
      checkOutput("reset_err_timeout", err_timeout, 0);
      checkOutput("reset_rsp_value", rsp_value, 0);
      rst_n = 1'b1;

      tbls[0][5][2] = '{valid: 1'b1, key: 32'h1234, vptr: 8'd7};
      vals[7] = 64'hA5A5_0123_4567_89AB;
      applyStimulus(32'h1234, 5, 9, 8'h3C, 0);

      tbls[0][12][0] = '{valid: 1'b0, key: 32'h55, vptr: 8'h11};
      tbls[1][20][3] = '{valid: 1'b1, key: 32'h55, vptr: 8'h3C};
      applyStimulus(32'h55, 12, 20, 8'h01, 1);

      applyStimulus(32'hDEAD_BEEF, 30, 31, 8'h77, 0);

      d0 = 0; d1 = 4;
      applyStimulus(32'h1234, 5, 9, 8'h42, 10);
      d0 = 0; d1 = 0;

      withholdV = 1'b1;
      applyStimulus(32'h55, 12, 20, 8'h99, 2);
      withholdV = 1'b0;
      applyStimulus(32'h1234, 5, 9, 8'h9A, 0);

      for (int n = 0; n < 30; n++) begin
         k = $urandom;
         i0 = $urandom_range(0, NB - 1);
         i1 = $urandom_range(0, NB - 1);
         randomBucket(0, i0, k);
         if (i1 != i0 || $urandom_range(0, 1) == 1) randomBucket(1, i1, k);
         d0 = $urandom_range(0, 5);
         d1 = $urandom_range(0, 5);
         dv = $urandom_range(0, 3);
         applyStimulus(k, i0, i1, IN'($urandom), $urandom_range(0, 3));
      end
      d0 = 0; d1 = 0; dv = 0;

      // Reset while the value read is outstanding must drop the lookup and clear the sticky flag.
      withholdV = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_key = 32'h1234; req_idx0 = DN'(5); req_idx1 = DN'(9); req_id = 8'h5E;
      @(posedge clk); #1;
      req_valid = 1'b0;
      b = 0;
      while (!v_rd && b < 20) begin
         @(posedge clk); #1;
         b++;
      end
      checkOutput("reach_val_wait", v_rd, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_req_ready", req_ready, 1);
      checkOutput("midrst_rsp_valid", rsp_valid, 0);
      checkOutput("midrst_strobes", {t0_rd, t1_rd, v_rd}, 0);
      checkOutput("midrst_err_timeout", err_timeout, 0);
      rst_n = 1'b1;
      stickyErr = 1'b0;
      withholdV = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("after_rst_no_rsp", rsp_valid, 0);
      applyStimulus(32'h1234, 5, 9, 8'h61, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
